matrix_operand_loader: RTL and testbench

//  Upstream stage of the matrix coprocessor's element-wise ALU (add/sub units).

---
 rtl/coproc_pkg.sv | 46 ++++
 rtl/matrix_lane_packer.sv | 25 ++
 rtl/matrix_operand_loader.sv | 132 +++++++++++++
 tb/tb_matrix_operand_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared types and helpers for the matrix coprocessor operand path.
// Size encodings map to element and word counts used by the loader.
package coproc_pkg;

  localparam int ELEM_W     = 8;
  localparam int MAX_ELEMS  = 25;
  localparam int WORD_LANES = 4;
  localparam int WORD_W     = ELEM_W * WORD_LANES;
  localparam int MAT_W      = ELEM_W * MAX_ELEMS;
  localparam int CNT_W      = 3;
  localparam int NEL_W      = 5;

  typedef enum logic [1:0] {
    SIZE_2X2 = 2'b00,
    SIZE_3X3 = 2'b01,
    SIZE_4X4 = 2'b10,
    SIZE_5X5 = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    HOLD   = 2'd3
  } loader_state_e;

  function automatic logic [NEL_W-1:0] n_elems(input logic [1:0] size);
    case (size)
      SIZE_2X2: n_elems = 5'd4;
      SIZE_3X3: n_elems = 5'd9;
      SIZE_4X4: n_elems = 5'd16;
      default:  n_elems = 5'd25;
    endcase
  endfunction

  // Words per matrix, ceil(N / WORD_LANES).
  function automatic logic [CNT_W-1:0] n_words(input logic [1:0] size);
    case (size)
      SIZE_2X2: n_words = 3'd1;
      SIZE_3X3: n_words = 3'd3;
      SIZE_4X4: n_words = 3'd4;
      default:  n_words = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/matrix_lane_packer.sv
// Combinational lane writer: overlays the lanes of one input word onto a
// packed matrix register, skipping elements at or beyond the active count.
module matrix_lane_packer
  import coproc_pkg::*;
(
  input  logic [MAT_W-1:0]  i_matrix,
  input  logic [CNT_W-1:0]  i_word_idx,
  input  logic [WORD_W-1:0] i_data,
  input  logic [NEL_W-1:0]  i_n_elems,
  output logic [MAT_W-1:0]  o_matrix
);

  // Each element has a fixed word/lane home, so the selection is a constant per slice.
  for (genvar gi = 0; gi < MAX_ELEMS; gi++) begin : g_elem
    localparam int WORD_IDX = gi / WORD_LANES;
    localparam int LANE_IDX = gi % WORD_LANES;

    logic w_hit;
    assign w_hit = (i_word_idx == CNT_W'(WORD_IDX)) && (i_n_elems > NEL_W'(gi));

    assign o_matrix[gi*ELEM_W +: ELEM_W] = w_hit ? i_data[LANE_IDX*ELEM_W +: ELEM_W]
                                                 : i_matrix[gi*ELEM_W +: ELEM_W];
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Packs matrix A then matrix B from 4-lane host words into row-major operand
// registers and holds them for the ALU until acknowledged.
module matrix_operand_loader
  import coproc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        size_in,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic [MAT_W-1:0]  matrix_a,
  output logic [MAT_W-1:0]  matrix_b,
  output logic [1:0]        matrix_size,
  output logic              operands_valid,
  input  logic              operands_ack,
  output logic              busy,
  output logic              start_err
);

  loader_state_e     r_state, w_state_next;
  logic [CNT_W-1:0]  r_word_cnt, w_word_cnt_next;
  logic [MAT_W-1:0]  r_matrix_a, w_matrix_a_next;
  logic [MAT_W-1:0]  r_matrix_b, w_matrix_b_next;
  logic [1:0]        r_size, w_size_next;
  logic              r_in_ready, r_valid, r_busy, r_start_err;

  logic              w_xfer;
  logic              w_last_word;
  logic [MAT_W-1:0]  w_pack_src;
  logic [MAT_W-1:0]  w_packed;

  assign w_xfer      = in_valid && r_in_ready;
  assign w_last_word = (r_word_cnt == (n_words(r_size) - 3'd1));
  assign w_pack_src  = (r_state == LOAD_B) ? r_matrix_b : r_matrix_a;

  matrix_lane_packer u_packer (
    .i_matrix   (w_pack_src),
    .i_word_idx (r_word_cnt),
    .i_data     (in_data),
    .i_n_elems  (n_elems(r_size)),
    .o_matrix   (w_packed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_word_cnt_next = r_word_cnt;
    w_matrix_a_next = r_matrix_a;
    w_matrix_b_next = r_matrix_b;
    w_size_next     = r_size;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_size_next     = size_in;
          w_matrix_a_next = '0;
          w_matrix_b_next = '0;
          w_word_cnt_next = '0;
          w_state_next    = LOAD_A;
        end
      end
      LOAD_A: begin
        if (w_xfer) begin
          w_matrix_a_next = w_packed;
          if (w_last_word) begin
            w_word_cnt_next = '0;
            w_state_next    = LOAD_B;
          end else begin
            w_word_cnt_next = r_word_cnt + 3'd1;
          end
        end
      end
      LOAD_B: begin
        if (w_xfer) begin
          w_matrix_b_next = w_packed;
          if (w_last_word) begin
            w_word_cnt_next = '0;
            w_state_next    = HOLD;
          end else begin
            w_word_cnt_next = r_word_cnt + 3'd1;
          end
        end
      end
      HOLD: begin
        if (operands_ack) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Status flags are derived from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_cnt  <= '0;
      r_matrix_a  <= '0;
      r_matrix_b  <= '0;
      r_size      <= 2'b00;
      r_in_ready  <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_word_cnt  <= w_word_cnt_next;
      r_matrix_a  <= w_matrix_a_next;
      r_matrix_b  <= w_matrix_b_next;
      r_size      <= w_size_next;
      r_in_ready  <= (w_state_next == LOAD_A) || (w_state_next == LOAD_B);
      r_valid     <= (w_state_next == HOLD);
      r_busy      <= (w_state_next != IDLE);
      r_start_err <= start && (r_state != IDLE);
    end
  end

  assign in_ready       = r_in_ready;
  assign matrix_a       = r_matrix_a;
  assign matrix_b       = r_matrix_b;
  assign matrix_size    = r_size;
  assign operands_valid = r_valid;
  assign busy           = r_busy;
  assign start_err      = r_start_err;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader: expected operands are queued at
// stimulus time and compared when operands_valid rises.
module tb_matrix_operand_loader;

  logic         clk = 1'b0;
  logic         reset, start, in_valid, operands_ack;
  logic [1:0]   size_in;
  logic [31:0]  in_data;
  logic         in_ready, operands_valid, busy, start_err;
  logic [199:0] matrix_a, matrix_b;
  logic [1:0]   matrix_size;

  int n_vec = 0;
  int n_err = 0;

  logic [199:0] q_a[$];
  logic [199:0] q_b[$];
  logic [1:0]   q_sz[$];
  int           q_lat[$];
  logic [199:0] last_a, last_b;

  always #5 clk = ~clk;

  matrix_operand_loader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .size_in        (size_in),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .matrix_a       (matrix_a),
    .matrix_b       (matrix_b),
    .matrix_size    (matrix_size),
    .operands_valid (operands_valid),
    .operands_ack   (operands_ack),
    .busy           (busy),
    .start_err      (start_err)
  );

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nel(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4;
      2'b01:   return 9;
      2'b10:   return 16;
      default: return 25;
    endcase
  endfunction

  // Lane j of a matrix stream carries base + step*j; lanes past N must be dropped.
  task automatic run_load(input logic [1:0] sz, input int a_base, input int a_step,
                          input int b_base, input int b_step, input int gap, input bit err_b);
    int n, w, lat, base, step;
    logic [199:0] ea, eb;
    logic [31:0]  word;
    n  = nel(sz);
    w  = (n + 3) / 4;
    ea = '0;
    eb = '0;
    for (int j = 0; j < n; j++) begin
      ea[j*8 +: 8] = 8'(a_base + a_step * j);
      eb[j*8 +: 8] = 8'(b_base + b_step * j);
    end
    q_a.push_back(ea);
    q_b.push_back(eb);
    q_sz.push_back(sz);
    q_lat.push_back(1 + 2 * w + gap * 2 * w);

    start   = 1'b1;
    size_in = sz;
    tick();
    start   = 1'b0;
    size_in = 2'(~sz);
    lat     = 1;
    check("clear_a", matrix_a, '0);
    check("clear_b", matrix_b, '0);
    check("busy_load", busy, 1'b1);

    for (int m = 0; m < 2; m++) begin
      base = (m == 0) ? a_base : b_base;
      step = (m == 0) ? a_step : b_step;
      for (int wi = 0; wi < w; wi++) begin
        for (int g = 0; g < gap; g++) begin
          in_valid     = 1'b0;
          in_data      = $urandom;
          operands_ack = 1'b1;
          tick();
          lat++;
          operands_ack = 1'b0;
        end
        for (int k = 0; k < 4; k++) word[k*8 +: 8] = 8'(base + step * (4 * wi + k));
        check("in_ready_load", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = word;
        if (err_b && m == 1 && wi == 1) start = 1'b1;
        tick();
        lat++;
        in_valid = 1'b0;
        if (start) begin
          start = 1'b0;
          check("start_err_loadb", start_err, 1'b1);
        end
      end
    end
    collect(lat);
  endtask

  task automatic collect(input int lat);
    int extra;
    logic [199:0] ea, eb;
    logic [1:0]   es;
    extra = 0;
    while (!operands_valid && extra < 50) begin
      tick();
      extra++;
    end
    if (!operands_valid) check("valid_timeout", operands_valid, 1'b1);
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    es = q_sz.pop_front();
    check("latency", lat + extra, q_lat.pop_front());
    check("matrix_a", matrix_a, ea);
    check("matrix_b", matrix_b, eb);
    check("matrix_size", matrix_size, es);
    check("in_ready_hold", in_ready, 1'b0);
    check("busy_hold", busy, 1'b1);
    last_a = ea;
    last_b = eb;
    $display("load size=%0d latency=%0d a[31:0]=%08h b[31:0]=%08h",
             es, lat + extra, matrix_a[31:0], matrix_b[31:0]);
  endtask

  task automatic ack_hold(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("valid_held", operands_valid, 1'b1);
      check("a_stable", matrix_a, last_a);
      check("b_stable", matrix_b, last_b);
      check("in_ready_held", in_ready, 1'b0);
    end
    operands_ack = 1'b1;
    tick();
    operands_ack = 1'b0;
    check("valid_after_ack", operands_valid, 1'b0);
    check("busy_after_ack", busy, 1'b0);
    check("a_kept_idle", matrix_a, last_a);
    $display("ack after %0d hold cycles", n);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; operands_ack = 1'b0;
    size_in = 2'b00; in_data = '0;
    repeat (3) tick();
    check("rst_a", matrix_a, '0);
    check("rst_b", matrix_b, '0);
    check("rst_size", matrix_size, 2'b00);
    check("rst_flags", {in_ready, operands_valid, busy, start_err}, 4'b0000);
    reset = 1'b0;

    // Words and acks in IDLE must be ignored.
    in_valid = 1'b1; in_data = 32'hDEADBEEF; operands_ack = 1'b1;
    tick();
    in_valid = 1'b0; operands_ack = 1'b0;
    check("idle_ignore_a", matrix_a, '0);
    check("idle_flags", {in_ready, operands_valid, busy, start_err}, 4'b0000);
    $display("reset and idle checks done");

    run_load(2'b00, 1, 1, 8'hFF, -1, 0, 1'b0);
    ack_hold(5);

    run_load(2'b01, 8'h11, 1, 8'hA0, 1, 1, 1'b0);
    ack_hold(1);

    run_load(2'b11, 1, 1, 26, 1, 0, 1'b0);
    ack_hold(0);

    run_load(2'b10, 8'h80, 3, 8'h7F, -5, 0, 1'b1);
    start = 1'b1; operands_ack = 1'b1;
    tick();
    start = 1'b0; operands_ack = 1'b0;
    check("sa_valid", operands_valid, 1'b0);
    check("sa_busy", busy, 1'b0);
    check("sa_start_err", start_err, 1'b1);
    tick();
    check("sa_no_load", {busy, in_ready}, 2'b00);
    check("sa_err_pulse", start_err, 1'b0);
    $display("start+ack in hold handled");

    start = 1'b1; size_in = 2'b11;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h01020304 + i;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_a", matrix_a, '0);
    check("midrst_b", matrix_b, '0);
    check("midrst_size", matrix_size, 2'b00);
    check("midrst_flags", {in_ready, operands_valid, busy, start_err}, 4'b0000);
    tick();
    check("midrst_idle", {in_ready, busy}, 2'b00);
    $display("reset mid-load done");

    run_load(2'b00, 8'h55, 8'h11, 8'hC3, 7, 0, 1'b0);
    ack_hold(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule
